axi_ram_cmd_mem: RTL and testbench

Memory backend that sits on the far side of the AXI RAM command interface: it accepts single-beat write and read commands from the AXI-to-RAM front end, performs byte-strobed writes into an inferred block RAM, and returns read data with ID and last flag over a valid/ready response channel. A two-stage read pipeline holds registered RAM output and an output register, so RAM inference stays clean while the response channel is fully back-pressurable at one beat per cycle.

---
 rtl/axi_ram_cmd_mem.sv | 113 +++++++++++
 tb/tb_axi_ram_cmd_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_cmd_mem.sv
// Memory backend for the AXI RAM command interface.
// Single-beat byte-strobed writes into an inferred block RAM. Reads return
// through a two-stage pipeline: registered RAM output (s1), then an output
// register. The response channel accepts back-pressure while sustaining one
// beat per cycle.
module axi_ram_cmd_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int STRB_WIDTH  = DATA_WIDTH/8,
  parameter int ID_WIDTH    = 8,
  parameter int RUSER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_WIDTH-1:0]    ram_cmd_id,
  input  logic [ADDR_WIDTH-1:0]  ram_cmd_addr,
  input  logic [DATA_WIDTH-1:0]  ram_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb,
  input  logic                   ram_cmd_wr_en,
  input  logic                   ram_cmd_rd_en,
  input  logic                   ram_cmd_last,
  output logic                   ram_cmd_ready,
  output logic [ID_WIDTH-1:0]    ram_rd_resp_id,
  output logic [DATA_WIDTH-1:0]  ram_rd_resp_data,
  output logic                   ram_rd_resp_last,
  output logic [RUSER_WIDTH-1:0] ram_rd_resp_user,
  output logic                   ram_rd_resp_valid,
  input  logic                   ram_rd_resp_ready
);

  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_WIDTH = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH      = 2**WORD_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0]   s1_id_q;
  logic                  s1_last_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  logic                  out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  out_adv, s1_adv;
  logic                  wr_acc, rd_acc;
  logic [WORD_WIDTH-1:0] word_idx;
  logic                  unused_addr_lsb;

  assign word_idx        = ram_cmd_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign unused_addr_lsb = ^ram_cmd_addr[ADDR_LSB-1:0];

  // Pipeline advance conditions and command acceptance (write wins over read)
  always_comb begin
    out_adv       = !out_valid_q || ram_rd_resp_ready;
    s1_adv        = !s1_valid_q || out_adv;
    ram_cmd_ready = s1_adv && !rst;
    wr_acc        = ram_cmd_wr_en && ram_cmd_ready;
    rd_acc        = ram_cmd_rd_en && !ram_cmd_wr_en && ram_cmd_ready;
    s1_valid_d    = s1_adv ? rd_acc : s1_valid_q;
    out_valid_d   = out_adv ? s1_valid_q : out_valid_q;
  end

  // Byte-strobed write into RAM; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (ram_cmd_wr_strb[i]) begin
          mem_q[word_idx][i*8 +: 8] <= ram_cmd_wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read feeding stage 1 data (kept reset-free for inference)
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      s1_data_q <= mem_q[word_idx];
    end
  end

  // Stage 1 sideband and output register, with valid flags under reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (rd_acc) begin
        s1_id_q   <= ram_cmd_id;
        s1_last_q <= ram_cmd_last;
      end
      if (out_adv) begin
        out_id_q   <= s1_id_q;
        out_data_q <= s1_data_q;
        out_last_q <= s1_last_q;
      end
    end
  end

  assign ram_rd_resp_id    = out_id_q;
  assign ram_rd_resp_data  = out_data_q;
  assign ram_rd_resp_last  = out_last_q;
  assign ram_rd_resp_user  = '0;
  assign ram_rd_resp_valid = out_valid_q;

endmodule

// File: tb/tb_axi_ram_cmd_mem.sv
// Directed bench for axi_ram_cmd_mem with hand-computed expectations.
module tb_axi_ram_cmd_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ram_cmd_id;
  logic [15:0] ram_cmd_addr;
  logic [31:0] ram_cmd_wr_data;
  logic [3:0]  ram_cmd_wr_strb;
  logic        ram_cmd_wr_en;
  logic        ram_cmd_rd_en;
  logic        ram_cmd_last;
  logic        ram_cmd_ready;
  logic [7:0]  ram_rd_resp_id;
  logic [31:0] ram_rd_resp_data;
  logic        ram_rd_resp_last;
  logic [0:0]  ram_rd_resp_user;
  logic        ram_rd_resp_valid;
  logic        ram_rd_resp_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  axi_ram_cmd_mem #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .ID_WIDTH(8),
    .RUSER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ram_cmd_id(ram_cmd_id),
    .ram_cmd_addr(ram_cmd_addr),
    .ram_cmd_wr_data(ram_cmd_wr_data),
    .ram_cmd_wr_strb(ram_cmd_wr_strb),
    .ram_cmd_wr_en(ram_cmd_wr_en),
    .ram_cmd_rd_en(ram_cmd_rd_en),
    .ram_cmd_last(ram_cmd_last),
    .ram_cmd_ready(ram_cmd_ready),
    .ram_rd_resp_id(ram_rd_resp_id),
    .ram_rd_resp_data(ram_rd_resp_data),
    .ram_rd_resp_last(ram_rd_resp_last),
    .ram_rd_resp_user(ram_rd_resp_user),
    .ram_rd_resp_valid(ram_rd_resp_valid),
    .ram_rd_resp_ready(ram_rd_resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow #1 later
  task automatic step();
    @(negedge clk);
    ram_cmd_wr_en = 1'b0;
    ram_cmd_rd_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    step();
    ram_cmd_wr_en = 1'b1; ram_cmd_addr = a; ram_cmd_wr_data = d; ram_cmd_wr_strb = s;
    #1 chk("wr_ready", ram_cmd_ready, 1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] id, input logic l);
    step();
    ram_cmd_rd_en = 1'b1; ram_cmd_addr = a; ram_cmd_id = id; ram_cmd_last = l;
    #1 chk("rd_ready", ram_cmd_ready, 1);
  endtask

  // Read then expect the beat exactly two cycles after acceptance
  task automatic rd_expect(input string tag, input logic [15:0] a, input logic [7:0] id,
                           input logic l, input logic [31:0] d);
    rd(a, id, l);
    step(); #1 chk({tag, "_n1_valid"}, ram_rd_resp_valid, 0);
    step(); #1;
    chk({tag, "_valid"}, ram_rd_resp_valid, 1);
    chk({tag, "_data"}, ram_rd_resp_data, d);
    chk({tag, "_id"}, ram_rd_resp_id, id);
    chk({tag, "_last"}, ram_rd_resp_last, l);
    step(); #1 chk({tag, "_drain"}, ram_rd_resp_valid, 0);
  endtask

  // 8-beat read burst over words 0..7; resp_ready low for cycles stall_lo..stall_hi
  task automatic burst(input string tag, input int stall_lo, input int stall_hi, input int last_v);
    int unsigned issued = 0;
    int unsigned rcvd = 0;
    logic stalled;
    for (int c = 0; c <= last_v + 1; c++) begin
      @(negedge clk);
      stalled = (c >= stall_lo) && (c <= stall_hi);
      ram_rd_resp_ready = !stalled;
      ram_cmd_wr_en = 1'b0;
      if (issued < 8) begin
        ram_cmd_rd_en = 1'b1;
        ram_cmd_addr  = 16'(issued * 4);
        ram_cmd_id    = 8'(issued);
        ram_cmd_last  = (issued == 7);
      end else begin
        ram_cmd_rd_en = 1'b0;
      end
      #1;
      chk({tag, "_ready"}, ram_cmd_ready, !stalled);
      chk({tag, "_valid"}, ram_rd_resp_valid, (c >= 2) && (c <= last_v));
      if (ram_rd_resp_valid) begin
        chk({tag, "_data"}, ram_rd_resp_data, 32'hC0DE_0000 | rcvd);
        chk({tag, "_id"}, ram_rd_resp_id, 8'(rcvd));
        chk({tag, "_last"}, ram_rd_resp_last, rcvd == 7);
        if (ram_rd_resp_ready) rcvd++;
      end
      if (ram_cmd_ready && ram_cmd_rd_en) issued++;
    end
    step();
    ram_rd_resp_ready = 1'b1;
    chk({tag, "_beats"}, rcvd, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ram_cmd_id = '0; ram_cmd_addr = '0; ram_cmd_wr_data = '0; ram_cmd_wr_strb = '0;
    ram_cmd_wr_en = 1'b0; ram_cmd_rd_en = 1'b0; ram_cmd_last = 1'b0;
    ram_rd_resp_ready = 1'b1;

    // Reset state
    step(); step(); #1;
    chk("rst_ready", ram_cmd_ready, 0);
    chk("rst_valid", ram_rd_resp_valid, 0);
    chk("rst_id", ram_rd_resp_id, 0);
    chk("rst_data", ram_rd_resp_data, 0);
    chk("rst_last", ram_rd_resp_last, 0);
    chk("rst_user", ram_rd_resp_user, 0);
    step(); rst = 1'b0;
    #1 chk("post_rst_ready", ram_cmd_ready, 1);

    // Full-word write then read back
    wr(16'h0010, 32'hDEADBEEF, 4'hF);
    rd_expect("basic", 16'h0010, 8'h05, 1'b1, 32'hDEADBEEF);

    // Partial strobes; low address bits ignored
    wr(16'h0020, 32'hFFFFFFFF, 4'hF);
    wr(16'h0020, 32'h00000000, 4'h5);
    rd_expect("strb", 16'h0022, 8'h06, 1'b0, 32'hFF00FF00);

    // Zero strobe is a no-op
    wr(16'h0020, 32'h12121212, 4'h0);
    rd_expect("strb0", 16'h0020, 8'h07, 1'b1, 32'hFF00FF00);

    // Burst contents: word k holds 0xC0DE000k
    for (int k = 0; k < 8; k++) wr(16'(k * 4), 32'hC0DE_0000 | k, 4'hF);

    burst("burst", 100, 0, 9);
    burst("bp", 3, 7, 14);

    // Simultaneous write and read: write only, no response
    step();
    ram_cmd_wr_en = 1'b1; ram_cmd_rd_en = 1'b1; ram_cmd_addr = 16'h0040;
    ram_cmd_wr_data = 32'h12345678; ram_cmd_wr_strb = 4'hF; ram_cmd_id = 8'h09;
    for (int k = 0; k < 3; k++) begin
      step(); #1 chk("wrrd_noresp", ram_rd_resp_valid, 0);
    end
    rd_expect("wrrd", 16'h0040, 8'h0A, 1'b1, 32'h12345678);

    // Reset with two reads in flight
    rd(16'h0010, 8'h21, 1'b0);
    rd(16'h0014, 8'h22, 1'b1);
    step(); rst = 1'b1;
    #1 chk("mid_rst_ready", ram_cmd_ready, 0);
    chk("mid_rst_pre_valid", ram_rd_resp_valid, 1);
    step(); rst = 1'b0;
    #1 chk("mid_rst_valid", ram_rd_resp_valid, 0);
    chk("mid_rst_ready_after", ram_cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step(); #1 chk("mid_rst_no_stale", ram_rd_resp_valid, 0);
    end
    rd_expect("mem_kept", 16'h0014, 8'h23, 1'b0, 32'hC0DE0005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
